vga_s00_axi_regs: RTL

AXI4-Lite slave register file for the VGA peripheral. It terminates the S00_AXI port driven by the system master, which is the BFM in simulation and the PS interconnect on hardware. It holds four 32-bit read/write control registers. It exports their contents, plus per-register write strobes, to the VGA timing/pixel core downstream.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_axil_wr_chan.sv | 91 +++++++++
 rtl/vga_s00_axi_regs.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and helpers for the VGA AXI4-Lite register slave
package vga_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         ADDR_LSB      = 2;
  localparam int         NUM_REGS      = 4;

  // Word index of each control register inside the 16-byte window
  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_COLOR = 2'd1,
    REG_HSYNC = 2'd2,
    REG_VSYNC = 2'd3
  } reg_idx_e;

  // Merge new write data into an old word, one byte lane per strobe bit
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_axil_wr_chan.sv
// rtl/vga_axil_wr_chan.sv - AXI4-Lite write channel: AW/W latch, commit and B response
module vga_axil_wr_chan
  import vga_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic                bvalid,
  input  logic                bready,
  output logic                commit,
  output logic [1:0]          commit_idx,
  output logic [DATA_W-1:0]   commit_data,
  output logic [DATA_W/8-1:0] commit_strb
);

  logic                aw_held;
  logic                w_held;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic aw_hs;
  logic w_hs;
  logic aw_held_n;
  logic w_held_n;
  logic bvalid_n;

  // Byte offset bits never select anything; only the word index matters
  logic unused_addr_bits;
  assign unused_addr_bits = ^awaddr_q[ADDR_LSB-1:0];

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // The first cycle with both halves held is the commit cycle
  assign commit      = aw_held && w_held;
  assign commit_idx  = awaddr_q[ADDR_LSB +: 2];
  assign commit_data = wdata_q;
  assign commit_strb = wstrb_q;

  // Next-state of the hold flags and the response; readies are derived from these
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = bvalid;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b1;
    end else begin
      if (aw_hs) aw_held_n = 1'b1;
      if (w_hs)  w_held_n  = 1'b1;
      if (bvalid && bready) bvalid_n = 1'b0;
    end
  end

  // Hold flags, registered readies (low while anything held or B pending) and latched payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      bvalid  <= bvalid_n;
      awready <= !aw_held_n && !bvalid_n;
      wready  <= !w_held_n && !bvalid_n;
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/vga_s00_axi_regs.sv
// rtl/vga_s00_axi_regs.sv - AXI4-Lite slave holding the four VGA control registers
module vga_s00_axi_regs
  import vga_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [NUM_REGS-1:0]             wr_stb_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic [DW-1:0]   regs [NUM_REGS];
  logic            commit;
  logic [1:0]      commit_idx;
  logic [DW-1:0]   commit_data;
  logic [DW/8-1:0] commit_strb;
  logic [1:0]      rd_idx;

  // Protection bits and read byte offset carry no meaning for this block
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign rd_idx = S_AXI_ARADDR[ADDR_LSB +: 2];

  assign S_AXI_BRESP = AXI_RESP_OKAY;
  assign S_AXI_RRESP = AXI_RESP_OKAY;

  assign reg0_o = regs[REG_CTRL];
  assign reg1_o = regs[REG_COLOR];
  assign reg2_o = regs[REG_HSYNC];
  assign reg3_o = regs[REG_VSYNC];

  vga_axil_wr_chan #(
    .DATA_W (DW),
    .ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_wr_chan (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .bvalid      (S_AXI_BVALID),
    .bready      (S_AXI_BREADY),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  // Strobe to the VGA core for the register being committed, even with an all-zero WSTRB
  always_comb begin
    wr_stb_o = '0;
    if (commit) wr_stb_o[commit_idx] = 1'b1;
  end

  // Register array: byte-lane update on the commit edge
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int k = 0; k < DW/8; k++) begin
        if (commit_strb[k]) regs[commit_idx][8*k +: 8] <= commit_data[8*k +: 8];
      end
    end
  end

  // Read channel: accept when no data pending, hold RDATA/RVALID until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      S_AXI_RDATA   <= regs[rd_idx];
      S_AXI_RVALID  <= 1'b1;
      S_AXI_ARREADY <= 1'b0;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end else if (!S_AXI_RVALID) begin
      S_AXI_ARREADY <= 1'b1;
    end
  end

endmodule
